// File: rtl/pipeline_ctrl_unit.sv
// Front-of-pipeline sequencing: load-use stall, branch flush and run/step/halt/drain debug FSM.
// Optional statistics counters are built when PIPE_CTRL_STATS_EN is defined.
module pipeline_ctrl_unit #(
  parameter int NBITS_REG    = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter bit START_HALTED = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_ID_EX_MemRead,
  input  logic [NBITS_REG-1:0] i_ID_EX_Rt,
  input  logic [NBITS_REG-1:0] i_IF_ID_Rs,
  input  logic [NBITS_REG-1:0] i_IF_ID_Rt,
  input  logic                 i_Branch_Taken,
  input  logic                 i_Halt_Instr,
  input  logic                 i_Run_Req,
  input  logic                 i_Step_Req,
  input  logic                 i_Halt_Req,
  output logic                 o_PC_Write,
  output logic                 o_IF_ID_Write,
  output logic                 o_IF_ID_Flush,
  output logic                 o_ID_EX_Bubble,
  output logic                 o_Pipe_Enable,
  output logic                 o_Halted
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [31:0]          o_Stall_Count,
  output logic [31:0]          o_Flush_Count,
  output logic [31:0]          o_Cycle_Count
`endif
);

  // state    | meaning
  // S_RUN    | free running, hazard controls active
  // S_STEP   | one active cycle, then back to halted
  // S_DRAIN  | HALT decoded, retire EX/MEM/WB with front frozen
  // S_HALTED | everything frozen, waiting for debug run/step
  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_STEP   = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam state_t     RESET_STATE = START_HALTED ? S_HALTED : S_RUN;
  localparam logic [3:0] DRAIN_LOAD  = 4'(DRAIN_CYCLES - 1);

  state_t     state;
  logic [3:0] drain_cnt;
  logic       load_use;
  logic       active;

  assign load_use = i_ID_EX_MemRead && (i_ID_EX_Rt != '0) &&
                    ((i_ID_EX_Rt == i_IF_ID_Rs) || (i_ID_EX_Rt == i_IF_ID_Rt));
  assign active   = (state == S_RUN) || (state == S_STEP);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= RESET_STATE;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (i_Halt_Req) begin
            state <= S_HALTED;
          end else if (i_Halt_Instr && !load_use) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        S_HALTED: begin
          if (i_Run_Req)       state <= S_RUN;
          else if (i_Step_Req) state <= S_STEP;
        end
        S_STEP: begin
          if (i_Halt_Instr) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end else begin
            state <= S_HALTED;
          end
        end
        S_DRAIN: begin
          if (i_Halt_Req || drain_cnt == '0) state <= S_HALTED;
          else                               drain_cnt <= drain_cnt - 4'd1;
        end
        default: state <= S_HALTED;
      endcase
    end
  end

  always_comb begin
    o_PC_Write     = 1'b0;
    o_IF_ID_Write  = 1'b0;
    o_IF_ID_Flush  = 1'b0;
    o_ID_EX_Bubble = 1'b0;
    o_Pipe_Enable  = 1'b0;
    o_Halted       = (state == S_HALTED);
    if (active) begin
      o_Pipe_Enable = 1'b1;
      // Load-use wins over a taken branch: the branch operands are not valid yet.
      if (load_use) begin
        o_ID_EX_Bubble = 1'b1;
      end else begin
        o_PC_Write    = 1'b1;
        o_IF_ID_Write = 1'b1;
        o_IF_ID_Flush = i_Branch_Taken;
      end
    end else if (state == S_DRAIN) begin
      o_Pipe_Enable  = 1'b1;
      o_ID_EX_Bubble = 1'b1;
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_Stall_Count <= '0;
      o_Flush_Count <= '0;
      o_Cycle_Count <= '0;
    end else begin
      if (active && load_use && o_Stall_Count != 32'hFFFF_FFFF)
        o_Stall_Count <= o_Stall_Count + 32'd1;
      if (o_IF_ID_Flush && o_Flush_Count != 32'hFFFF_FFFF)
        o_Flush_Count <= o_Flush_Count + 32'd1;
      if (state != S_HALTED && o_Cycle_Count != 32'hFFFF_FFFF)
        o_Cycle_Count <= o_Cycle_Count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed plus randomized bench for pipeline_ctrl_unit against a behavioural model.
module tb_pipeline_ctrl_unit;

  localparam int NB = 5;
  localparam int DC = 3;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          mem_read = 1'b0;
  logic [NB-1:0] ex_rt = '0, id_rs = '0, id_rt = '0;
  logic          br = 1'b0, halt_instr = 1'b0, run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0;
  logic          pc_w, ifid_w, flush, bubble, pipe_en, halted;
`ifdef PIPE_CTRL_STATS_EN
  logic [31:0]   stall_cnt, flush_cnt, cycle_cnt;
`endif

  pipeline_ctrl_unit #(.NBITS_REG(NB), .DRAIN_CYCLES(DC), .START_HALTED(1'b1)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_ID_EX_MemRead(mem_read), .i_ID_EX_Rt(ex_rt), .i_IF_ID_Rs(id_rs), .i_IF_ID_Rt(id_rt),
    .i_Branch_Taken(br), .i_Halt_Instr(halt_instr),
    .i_Run_Req(run_req), .i_Step_Req(step_req), .i_Halt_Req(halt_req),
    .o_PC_Write(pc_w), .o_IF_ID_Write(ifid_w), .o_IF_ID_Flush(flush),
    .o_ID_EX_Bubble(bubble), .o_Pipe_Enable(pipe_en), .o_Halted(halted)
`ifdef PIPE_CTRL_STATS_EN
    , .o_Stall_Count(stall_cnt), .o_Flush_Count(flush_cnt), .o_Cycle_Count(cycle_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Model: mode names are the debug-unit view; drain_left counts remaining drain cycles.
  typedef enum int {M_RUN, M_STEP, M_DRAIN, M_HALTED} mode_t;
  mode_t mode = M_HALTED;
  int    drain_left = 0;
  int    n_cmp = 0, n_err = 0;
  longint m_stall = 0, m_flush = 0, m_cycle = 0;

  function automatic bit hazard();
    return mem_read && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
  endfunction

  // {PC_Write, IF_ID_Write, Flush, Bubble, Pipe_Enable, Halted}
  function automatic logic [5:0] expected();
    case (mode)
      M_HALTED: return 6'b000001;
      M_DRAIN:  return 6'b000110;
      default:  return hazard() ? 6'b000110 : (br ? 6'b111010 : 6'b110010);
    endcase
  endfunction

  function automatic logic [5:0] observed();
    return {pc_w, ifid_w, flush, bubble, pipe_en, halted};
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [5:0] e;
    e = expected();
    if (mode == M_RUN || mode == M_STEP) begin
      if (hazard()) m_stall++;
      if (e[3]) m_flush++;
    end
    if (mode != M_HALTED) m_cycle++;
    case (mode)
      M_RUN: begin
        if (halt_req) mode = M_HALTED;
        else if (halt_instr && !hazard()) begin mode = M_DRAIN; drain_left = DC; end
      end
      M_HALTED: begin
        if (run_req) mode = M_RUN;
        else if (step_req) mode = M_STEP;
      end
      M_STEP: begin
        if (halt_instr) begin mode = M_DRAIN; drain_left = DC; end
        else mode = M_HALTED;
      end
      default: begin
        drain_left--;
        if (halt_req || drain_left == 0) mode = M_HALTED;
      end
    endcase
  endtask

  // Inputs are driven at the falling edge; outputs checked 1ns later, then the model follows the rising edge.
  task automatic tick(input string tag);
    #1 check(tag, observed(), expected());
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
  endtask

  task automatic set_in(input bit mr, input int ert, input int rs, input int rt, input bit b,
                        input bit hi, input bit rn, input bit st, input bit hr);
    mem_read = mr; ex_rt = NB'(ert); id_rs = NB'(rs); id_rt = NB'(rt); br = b;
    halt_instr = hi; run_req = rn; step_req = st; halt_req = hr;
  endtask

  task automatic reset_mid(input string tag);
    #2 i_reset_n = 1'b0;
    #1;
    mode = M_HALTED; drain_left = 0; m_stall = 0; m_flush = 0; m_cycle = 0;
    check(tag, observed(), 6'b000001);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  initial begin
    @(negedge i_clk);
    @(negedge i_clk);
    #1 check("reset_state", observed(), 6'b000001);
    i_reset_n = 1'b1;
    @(negedge i_clk);

    set_in(0,0,0,0,0, 0,0,1,0); tick("halted_step_req");
    set_in(0,0,0,0,0, 0,0,0,0);
    #1 check("step_active", observed(), 6'b110010);
    tick("step_cycle");
    tick("step_back_halted");
    check("step_halted_const", observed(), 6'b000001);

    set_in(0,0,0,0,0, 0,1,0,0); tick("run_req");
    set_in(1,5,5,1,0, 0,1,0,0);
    #1 check("lu_rs_stall", observed(), 6'b000110);
    tick("lu_rs");
    set_in(1,0,0,1,0, 0,1,0,0); tick("rt_zero_no_stall");
    set_in(0,3,1,2,1, 0,1,0,0); tick("branch_flush");
    set_in(1,7,1,7,1, 0,1,0,0);
    #1 check("lu_beats_branch", observed(), 6'b000110);
    tick("lu_branch");

    set_in(1,4,4,0,0, 1,0,0,0); tick("halt_under_lu");
    set_in(0,0,0,0,0, 1,0,0,0); tick("halt_decode");
    set_in(0,0,0,0,0, 0,1,1,0);
    for (int i = 0; i < DC; i++) tick("drain_cycle");
    set_in(0,0,0,0,0, 0,0,0,0);
    #1 check("drain_done", observed(), 6'b000001);
    tick("halted_after_drain");

    set_in(0,0,0,0,0, 0,1,0,0); tick("run_again");
    set_in(0,0,0,0,0, 1,0,0,0); tick("halt_decode2");
    set_in(0,0,0,0,0, 0,0,0,0); tick("drain1");
    set_in(0,0,0,0,0, 0,0,0,1); tick("drain2_halt_req");
    set_in(0,0,0,0,0, 0,0,0,0);
    #1 check("halt_req_in_drain", observed(), 6'b000001);
    tick("halted3");

    set_in(0,0,0,0,0, 0,1,0,0); tick("run3");
    set_in(0,0,0,0,0, 1,0,0,0); tick("halt_decode3");
    set_in(0,0,0,0,0, 0,0,0,0); tick("drain_before_reset");
    reset_mid("reset_mid_drain");
    set_in(0,0,0,0,0, 0,1,0,0); tick("run_after_reset");
    set_in(0,0,0,0,0, 0,0,0,0);
    #1 check("run_after_reset_state", observed(), 6'b110010);
    tick("run_cycle");

    set_in(0,0,0,0,0, 0,0,0,1); tick("halt_req_run");
    set_in(0,0,0,0,0, 0,0,1,0);
    for (int i = 0; i < 6; i++) tick("held_step");

    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0,1), $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3),
             $urandom_range(0,3) == 0, $urandom_range(0,5) == 0,
             $urandom_range(0,3) == 0, $urandom_range(0,3) == 0, $urandom_range(0,19) == 0);
      if ($urandom_range(0,249) == 0) reset_mid("rand_reset");
      else tick("random");
    end

`ifdef PIPE_CTRL_STATS_EN
    #1;
    check("stall_count", 6'(stall_cnt), 6'(m_stall));
    check("flush_count", 6'(flush_cnt), 6'(m_flush));
    check("cycle_count", 6'(cycle_cnt), 6'(m_cycle));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl_unit.md
Name: pipeline_ctrl_unit

Overview:
Sequencing controller for the front of the 5-stage MIPS pipeline. It drives the PC write-enable and the IF/ID register write, flush and ID/EX bubble controls from load-use hazards and taken branches. It also runs a run/halt/single-step FSM for the debug unit, including draining the pipeline on a HALT instruction. It sits between the hazard sources (ID/EX fields, branch resolution in ID) and the PC, IF/ID and ID/EX registers.

Parameters:
NBITS_REG, 5, register-index width
DRAIN_CYCLES, 3, cycles to drain EX/MEM/WB after HALT decode before freezing (1..15)
START_HALTED, 1, 1: FSM leaves reset in HALTED; 0: in RUN

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_ID_EX_MemRead  in  1  instruction in EX is a load
i_ID_EX_Rt  in  NBITS_REG  load destination register
i_IF_ID_Rs  in  NBITS_REG  rs of instruction in ID
i_IF_ID_Rt  in  NBITS_REG  rt of instruction in ID
i_Branch_Taken  in  1  branch/jump resolved taken in ID this cycle
i_Halt_Instr  in  1  HALT opcode decoded in ID
i_Run_Req  in  1  debug: continuous run (level, sampled per cycle)
i_Step_Req  in  1  debug: single step (one-cycle pulse)
i_Halt_Req  in  1  debug: immediate halt
o_PC_Write  out  1  PC update enable
o_IF_ID_Write  out  1  IF/ID register load enable
o_IF_ID_Flush  out  1  clear IF/ID to NOP on next edge
o_ID_EX_Bubble  out  1  insert NOP into ID/EX
o_Pipe_Enable  out  1  clock enable for ID/EX, EX/MEM, MEM/WB
o_Halted  out  1  FSM in HALTED

Behaviour:
- States: RUN, STEP, DRAIN, HALTED, encoded in 2 bits. The FSM is registered. Outputs are combinational from the state and the inputs.
- Reset is asynchronous on i_reset_n low, mid-operation included. State goes to HALTED if START_HALTED=1, else RUN. The drain counter goes to 0.
- Reset output values with START_HALTED=1: all enables 0, Flush 0, Bubble 0, o_Halted 1.
- Load-use hazard (LU): i_ID_EX_MemRead=1 AND i_ID_EX_Rt!=0 AND (i_ID_EX_Rt==i_IF_ID_Rs OR i_ID_EX_Rt==i_IF_ID_Rt).
- RUN / STEP "active" outputs:
  - Pipe_Enable=1.
  - If LU: PC_Write=0, IF_ID_Write=0, Bubble=1, Flush=0. LU beats a taken branch, because branch operands are not ready yet.
  - Else if i_Branch_Taken: PC_Write=1, IF_ID_Write=1, Flush=1, Bubble=0.
  - Else: PC_Write=1, IF_ID_Write=1, Flush=0, Bubble=0.
- HALTED: all enables 0, Flush=0, Bubble=0, o_Halted=1. Hazard inputs are ignored.
- DRAIN: PC_Write=0, IF_ID_Write=0, Bubble=1, Pipe_Enable=1, Flush=0. The instructions ahead of HALT complete; HALT itself is replaced by a bubble.
- Transitions, evaluated every rising edge:
  - RUN: i_Halt_Req goes to HALTED (highest priority). Else i_Halt_Instr and not LU goes to DRAIN, loading counter=DRAIN_CYCLES-1. Else stay in RUN.
  - HALTED: i_Run_Req goes to RUN. Else i_Step_Req goes to STEP. Run wins if both are high.
  - STEP: exactly one active cycle. Next state is HALTED. If i_Halt_Instr, the next state is DRAIN instead.
  - DRAIN: counter decrements each cycle. At 0 go to HALTED. i_Halt_Req goes to HALTED immediately. i_Run_Req and i_Step_Req are ignored.
- HALT decoded while LU is active: the stall is taken first. DRAIN is entered on the cycle HALT is no longer stalled.
- A step-pulse held for more than one cycle produces one step per return to HALTED, so a level held high steps every second cycle.

Optional Feature:
Macro PIPE_CTRL_STATS_EN.
- Defined: adds outputs o_Stall_Count[31:0], o_Flush_Count[31:0] and o_Cycle_Count[31:0].
  - They increment on LU stall cycles, flush cycles and non-HALTED cycles respectively.
  - Each saturates at 32'hFFFFFFFF.
  - All reset to 0 on i_reset_n.
- Not defined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset with START_HALTED=1 -> o_Halted=1, o_PC_Write=0, o_Pipe_Enable=0. Pulse i_Step_Req -> exactly one cycle with PC_Write=1, then o_Halted=1 again.
- RUN, MemRead=1, ID_EX_Rt=5, IF_ID_Rs=5 -> PC_Write=0, IF_ID_Write=0, Bubble=1 that cycle. Same stimulus with Rt=0 -> no stall.
- RUN, i_Branch_Taken=1 with no LU -> Flush=1, PC_Write=1. With LU (Rt=7 matching IF_ID_Rt=7) and branch taken together -> Flush=0, Bubble=1.
- RUN, i_Halt_Instr=1, DRAIN_CYCLES=3 -> 3 cycles with PC_Write=0, Bubble=1, Pipe_Enable=1, then HALTED. Assert i_Halt_Req on the 2nd drain cycle -> HALTED on the next edge.
- i_reset_n asserted low mid-DRAIN (asynchronously, between clock edges) -> o_Halted=1 immediately, counter cleared. Release, then i_Run_Req=1 -> RUN on the next edge.
- With PIPE_CTRL_STATS_EN defined: 2 LU cycles plus 1 flush -> o_Stall_Count=2, o_Flush_Count=1. A forced counter value of 32'hFFFFFFFF stays saturated.
